rr_arbiter: RTL and testbench

//   Round-robin arbiter, the sequential successor to the combinational priority encoder.

---
 rtl/rr_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant and hold timeout
// Optional high-priority request mask enabled by defining RR_ARB_HIGH_PRIO_EN.
module rr_arbiter #(
   parameter int NUM_REQ  = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
`ifdef RR_ARB_HIGH_PRIO_EN
   input  logic [NUM_REQ-1:0]         high_prio,
`endif
   input  logic                       done,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       grant_valid,
   output logic                       timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic               timeout_q, timeout_d;

   logic [IDX_W-1:0]   next_ptr;
   logic [IDX_W-1:0]   search_ptr;
   logic [NUM_REQ-1:0] cand_base;
   logic [NUM_REQ-1:0] cand;
   logic               found;
   logic [IDX_W-1:0]   win;
   logic               expire;
   logic               release_now;

   assign next_ptr = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + 1'b1;
   assign expire   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
   assign release_now = done || !req[grant_idx_q] || expire;

   // In GRANT the current grantee is masked out so a release re-arbitrates among the others.
   always_comb begin
      cand_base  = req;
      search_ptr = ptr_q;
      if (state_q == GRANT) begin
         cand_base  = req & ~(NUM_REQ'(1) << grant_idx_q);
         search_ptr = next_ptr;
      end
   end

`ifdef RR_ARB_HIGH_PRIO_EN
   always_comb begin
      cand = cand_base;
      if (|(cand_base & high_prio)) cand = cand_base & high_prio;
   end
`else
   assign cand = cand_base;
`endif

   always_comb begin
      int unsigned idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(search_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && cand[IDX_W'(idx)]) begin
            found = 1'b1;
            win   = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      grant_idx_d = grant_idx_q;
      timeout_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = GRANT;
               grant_idx_d = win;
               hold_cnt_d  = '0;
            end
         end
         default: begin
            if (release_now) begin
               ptr_d      = next_ptr;
               timeout_d  = expire && !done;
               hold_cnt_d = '0;
               if (found) begin
                  state_d     = GRANT;
                  grant_idx_d = win;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
      endcase
      grant_d = (state_d == GRANT) ? (NUM_REQ'(1) << grant_idx_d) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
         grant_q     <= '0;
         grant_idx_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         timeout_q   <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = (state_q == GRANT);
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed self-checking bench for rr_arbiter (NUM_REQ=8, MAX_HOLD=4)
module tb_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;
`ifdef RR_ARB_HIGH_PRIO_EN
   logic [7:0] high_prio;
`endif

   int checks;
   int errors;

   rr_arbiter #(.NUM_REQ(8), .MAX_HOLD(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
`ifdef RR_ARB_HIGH_PRIO_EN
      .high_prio  (high_prio),
`endif
      .done       (done),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .grant_valid(grant_valid),
      .timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 8'hFF;
      done  = 1'b0;
      repeat (2) tick();
      checks++;
      if (grant !== 8'h00) begin errors++; $display("FAIL reset_grant: got %h expected %h", grant, 8'h00); end
      checks++;
      if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", grant_valid); end
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
         errors++; $display("FAIL reset_first_grant: got grant=%h idx=%0d valid=%b expected grant=01 idx=0 valid=1", grant, grant_idx, grant_valid);
      end
   endtask

   task automatic test_fairness();
      logic [7:0] exp_g;
      done = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_g = 8'h01 << (k % 8);
         checks++;
         if (grant !== exp_g || grant_idx !== 3'(k % 8) || grant_valid !== 1'b1) begin
            errors++; $display("FAIL fairness_step%0d: got grant=%h idx=%0d valid=%b expected grant=%h idx=%0d valid=1", k, grant, grant_idx, grant_valid, exp_g, k % 8);
         end
      end
   endtask

   task automatic test_wrap_and_mask();
      req  = 8'h81;
      done = 1'b1;
      tick();
      checks++;
      if (grant_idx !== 3'd7 || grant !== 8'h80) begin errors++; $display("FAIL wrap_to7: got grant=%h idx=%0d expected grant=80 idx=7", grant, grant_idx); end
      tick();
      checks++;
      if (grant_idx !== 3'd0 || grant !== 8'h01) begin errors++; $display("FAIL wrap_to0: got grant=%h idx=%0d expected grant=01 idx=0", grant, grant_idx); end
      req = 8'h01;
      tick();
      checks++;
      if (grant_valid !== 1'b0 || grant !== 8'h00) begin errors++; $display("FAIL lone_gap: got grant=%h valid=%b expected grant=00 valid=0", grant, grant_valid); end
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant !== 8'h01) begin errors++; $display("FAIL lone_regrant: got grant=%h idx=%0d valid=%b expected grant=01 idx=0 valid=1", grant, grant_idx, grant_valid); end
      done = 1'b0;
   endtask

   task automatic test_timeout();
      req = 8'h0C;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (grant_idx !== 3'd2 || grant !== 8'h04 || timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_hold%0d: got grant=%h idx=%0d timeout=%b expected grant=04 idx=2 timeout=0", c, grant, grant_idx, timeout);
         end
      end
      tick();
      checks++;
      if (timeout !== 1'b1 || grant_idx !== 3'd3 || grant !== 8'h08) begin
         errors++; $display("FAIL timeout_pulse: got grant=%h idx=%0d timeout=%b expected grant=08 idx=3 timeout=1", grant, grant_idx, timeout);
      end
      tick();
      checks++;
      if (timeout !== 1'b0 || grant_idx !== 3'd3) begin
         errors++; $display("FAIL timeout_clear: got idx=%0d timeout=%b expected idx=3 timeout=0", grant_idx, timeout);
      end
   endtask

   task automatic test_withdraw_and_async_reset();
      req  = 8'hA0;
      done = 1'b1;
      tick();
      checks++;
      if (grant_idx !== 3'd5 || grant !== 8'h20) begin errors++; $display("FAIL withdraw_setup: got grant=%h idx=%0d expected grant=20 idx=5", grant, grant_idx); end
      done = 1'b0;
      req  = 8'h80;
      tick();
      checks++;
      if (grant_idx !== 3'd7 || grant !== 8'h80 || grant_valid !== 1'b1) begin
         errors++; $display("FAIL withdraw_move: got grant=%h idx=%0d valid=%b expected grant=80 idx=7 valid=1", grant, grant_idx, grant_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
         errors++; $display("FAIL async_reset: got grant=%h idx=%0d valid=%b expected grant=00 idx=0 valid=0", grant, grant_idx, grant_valid);
      end
      req = 8'h00;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_done_beats_timeout();
      req  = 8'h03;
      done = 1'b0;
      tick();
      checks++;
      if (grant_idx !== 3'd0 || grant_valid !== 1'b1) begin errors++; $display("FAIL coincide_setup: got idx=%0d valid=%b expected idx=0 valid=1", grant_idx, grant_valid); end
      repeat (3) tick();
      done = 1'b1;
      tick();
      checks++;
      if (timeout !== 1'b0 || grant_idx !== 3'd1 || grant !== 8'h02) begin
         errors++; $display("FAIL coincide_done: got grant=%h idx=%0d timeout=%b expected grant=02 idx=1 timeout=0", grant, grant_idx, timeout);
      end
      done = 1'b0;
      req  = 8'h00;
      tick();
      checks++;
      if (grant_valid !== 1'b0) begin errors++; $display("FAIL idle_after_drop: got valid=%b expected 0", grant_valid); end
   endtask

`ifdef RR_ARB_HIGH_PRIO_EN
   task automatic test_high_prio();
      rst_n = 1'b0;
      req   = 8'h00;
      high_prio = 8'h00;
      tick();
      rst_n = 1'b1;
      req   = 8'h0F;
      high_prio = 8'h08;
      tick();
      checks++;
      if (grant_idx !== 3'd3 || grant !== 8'h08) begin errors++; $display("FAIL hp_first: got grant=%h idx=%0d expected grant=08 idx=3", grant, grant_idx); end
      done = 1'b1;
      high_prio = 8'h00;
      tick();
      checks++;
      if (grant_idx !== 3'd0 || grant !== 8'h01) begin errors++; $display("FAIL hp_after: got grant=%h idx=%0d expected grant=01 idx=0", grant, grant_idx); end
      done = 1'b0;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      req    = 8'h00;
      done   = 1'b0;
`ifdef RR_ARB_HIGH_PRIO_EN
      high_prio = 8'h00;
`endif
      test_reset();
      test_fairness();
      test_wrap_and_mask();
      test_timeout();
      test_withdraw_and_async_reset();
      test_done_beats_timeout();
`ifdef RR_ARB_HIGH_PRIO_EN
      test_high_prio();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
